// File: rtl/wheel_ctrl_pkg.sv
// Shared types, encoder word layout and saturation helper for the wheel speed PI loop.
package wheel_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, ERR, INTEG, MUL, OUT} state_t;

    localparam int unsigned ENC_DIR_BIT   = 16;
    localparam int unsigned ENC_SPEED_MSB = 15;
    localparam int unsigned SUM_W         = 34;

    function automatic logic signed [SUM_W-1:0] sat_s(input logic signed [SUM_W-1:0] x,
                                                      input logic signed [SUM_W-1:0] lo,
                                                      input logic signed [SUM_W-1:0] hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Sign/magnitude PWM generator; the duty command is only adopted at the period boundary.
module pwm_gen #(
    parameter int unsigned PWM_PERIOD = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] duty_cmd,
    output logic        pwm_out,
    output logic        dir_out
);

    localparam int unsigned CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

    logic [CW-1:0]      cnt_q;
    logic signed [15:0] duty_act_q;
    logic [15:0]        mag;
    logic               wrap;

    assign wrap = (cnt_q == CW'(PWM_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            duty_act_q <= '0;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + CW'(1);
            if (!enable) begin
                duty_act_q <= '0;
            end else if (wrap) begin
                duty_act_q <= duty_cmd;
            end
        end
    end

    always_comb begin
        mag     = duty_act_q[15] ? 16'(-duty_act_q) : duty_act_q;
        // Gating with enable drops the output in the same cycle the loop is disabled.
        pwm_out = enable && (32'(cnt_q) < 32'(mag));
        dir_out = !duty_act_q[15];
    end

endmodule

// File: rtl/wheel_speed_pi.sv
// Per-wheel PI speed loop: samples the encoder word on the window tick, runs a
// five-step saturating PI computation and drives a PWM/direction pair.
module wheel_speed_pi
    import wheel_ctrl_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 250000,
    parameter int unsigned PWM_PERIOD    = 1000,
    parameter int unsigned SHIFT         = 8,
    parameter int unsigned INT_LIM       = 32767
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] enc_in,
    input  logic        enable,
    input  logic [15:0] setpoint,
    input  logic [7:0]  kp,
    input  logic [7:0]  ki,
    output logic        pwm_out,
    output logic        dir_out,
    output logic        sat,
    output logic        sample_tick
);

    localparam int unsigned SCW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    localparam logic signed [SUM_W-1:0] ERR_HI = 34'sd32767;
    localparam logic signed [SUM_W-1:0] ERR_LO = -34'sd32768;
    localparam logic signed [SUM_W-1:0] INT_HI = 34'(INT_LIM);
    localparam logic signed [SUM_W-1:0] INT_LO = -INT_HI;
    localparam logic signed [SUM_W-1:0] PWM_HI = 34'(PWM_PERIOD);
    localparam logic signed [SUM_W-1:0] PWM_LO = -PWM_HI;

    state_t                   state_q, state_d;
    logic [SCW-1:0]           samp_cnt_q;
    logic signed [16:0]       meas_q, meas_d;
    logic signed [15:0]       sp_q, sp_d;
    logic signed [15:0]       err_q, err_d;
    logic signed [15:0]       integ_q, integ_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic signed [15:0]       duty_cmd_q, duty_cmd_d;
    logic                     sat_q, sat_d;

    logic signed [16:0]       speed_pos;
    logic signed [24:0]       p_prod, i_prod;
    logic signed [SUM_W-1:0]  wide, u;

    logic unused_enc;
    assign unused_enc = ^enc_in[31:17];

    assign sample_tick = (samp_cnt_q == SCW'(SAMPLE_PERIOD - 1));
    assign speed_pos   = signed'({1'b0, enc_in[ENC_SPEED_MSB:0]});
    assign sat         = sat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            samp_cnt_q <= '0;
            meas_q     <= '0;
            sp_q       <= '0;
            err_q      <= '0;
            integ_q    <= '0;
            sum_q      <= '0;
            duty_cmd_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= sample_tick ? '0 : samp_cnt_q + SCW'(1);
            meas_q     <= meas_d;
            sp_q       <= sp_d;
            err_q      <= err_d;
            integ_q    <= integ_d;
            sum_q      <= sum_d;
            duty_cmd_q <= duty_cmd_d;
            sat_q      <= sat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        meas_d     = meas_q;
        sp_d       = sp_q;
        err_d      = err_q;
        integ_d    = integ_q;
        sum_d      = sum_q;
        duty_cmd_d = duty_cmd_q;
        sat_d      = sat_q;
        p_prod     = '0;
        i_prod     = '0;
        wide       = '0;
        u          = '0;

        if (!enable) begin
            state_d    = IDLE;
            integ_d    = '0;
            duty_cmd_d = '0;
            sat_d      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sample_tick) begin
                        meas_d  = enc_in[ENC_DIR_BIT] ? speed_pos : -speed_pos;
                        sp_d    = setpoint;
                        state_d = ERR;
                    end
                end
                ERR: begin
                    wide    = sat_s(34'(sp_q) - 34'(meas_q), ERR_LO, ERR_HI);
                    err_d   = wide[15:0];
                    state_d = INTEG;
                end
                INTEG: begin
                    // Anti-windup: stop integrating while the output is pinned in the
                    // direction the error would push it further.
                    if (!(sat_q && (err_q[15] == duty_cmd_q[15]))) begin
                        wide    = sat_s(34'(integ_q) + 34'(err_q), INT_LO, INT_HI);
                        integ_d = wide[15:0];
                    end
                    state_d = MUL;
                end
                MUL: begin
                    p_prod  = 25'(signed'({1'b0, kp})) * 25'(err_q);
                    i_prod  = 25'(signed'({1'b0, ki})) * 25'(integ_q);
                    sum_d   = 34'(p_prod) + 34'(i_prod);
                    state_d = OUT;
                end
                OUT: begin
                    u          = sum_q >>> SHIFT;
                    wide       = sat_s(u, PWM_LO, PWM_HI);
                    duty_cmd_d = wide[15:0];
                    sat_d      = (wide != u);
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    pwm_gen #(
        .PWM_PERIOD(PWM_PERIOD)
    ) u_pwm (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .duty_cmd(duty_cmd_q),
        .pwm_out (pwm_out),
        .dir_out (dir_out)
    );

    tick_in_idle: assert property (@(posedge clk) disable iff (reset)
        (sample_tick && enable) |-> (state_q == IDLE));

endmodule

// File: doc/wheel_speed_pi.md
Name: wheel_speed_pi

Overview:
- Consumes the 32-bit speed/direction word from the quadrature encoder front-end and closes a PI speed loop for one wheel motor.
- The encoder word is {direction[15:0], speed[15:0]}: speed is the number of A/B edges in the last 250 000-clock window, and direction bit 0 = 1 means forward.
- The block samples that word on its own aligned window tick, computes a saturated PI command, and drives a glitch-free PWM plus a direction pin to the H-bridge.
- One instance per wheel.

Parameters:
- SAMPLE_PERIOD, 250000: clocks per control sample; must equal the encoder window.
- PWM_PERIOD, 1000: clocks per PWM period; also the max |duty|.
- SHIFT, 8: arithmetic right shift applied to the PI sum.
- INT_LIM, 32767: symmetric clamp for the integrator.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- enc_in, in, 32: encoder word; bit 16 = dir, [15:0] = edge count.
- enable, in, 1: loop enable.
- setpoint, in, 16: signed target in edges per window.
- kp, in, 8: unsigned proportional gain.
- ki, in, 8: unsigned integral gain.
- pwm_out, out, 1: PWM to the bridge.
- dir_out, out, 1: 1 = forward.
- sat, out, 1: last command was clamped.
- sample_tick, out, 1: one-cycle pulse when a sample is taken.

Behaviour:
- Reset is synchronous and active-high; one clock.
- Reset values:
  - pwm_out=0, dir_out=1, sat=0, sample_tick=0.
  - Integrator=0, duty_cmd=0, duty_act=0.
  - Both counters=0; FSM in IDLE.
- Sample counter:
  - Counts 0..SAMPLE_PERIOD-1 and wraps.
  - sample_tick=1 in the cycle the counter equals SAMPLE_PERIOD-1.
- Measurement, latched at the tick: meas = enc_in[16] ? +enc_in[15:0] : -enc_in[15:0], as a 17-bit signed value.
- FSM (one step per clock). With the tick at cycle T, duty_cmd is valid at T+4.
  - IDLE: on sample_tick, latch meas and go to ERR. Otherwise stay.
  - ERR: err = setpoint - meas (18-bit), saturated to 16-bit signed. Go to INTEG.
  - INTEG (anti-windup): if sat=1 and sign(err) equals sign(duty_cmd), hold the integrator. Otherwise integ = clamp(integ + err, ±INT_LIM). Go to MUL.
  - MUL: p = kp*err and i = ki*integ, signed with kp/ki zero-extended; sum is 34-bit. Go to OUT.
  - OUT: u = sum >>> SHIFT. duty_cmd = clamp(u, ±PWM_PERIOD). sat=1 iff the clamp was active. Go to IDLE.
- PWM:
  - Free-running counter 0..PWM_PERIOD-1.
  - duty_act <= duty_cmd only when the counter wraps to 0, so there are no mid-period glitches.
  - pwm_out = (counter < |duty_act|). dir_out = (duty_act >= 0).
  - duty=0 gives a constant 0. |duty|=PWM_PERIOD gives a constant 1.
- enable=0:
  - Integrator=0, duty_cmd=0, duty_act=0 immediately, pwm_out=0, sat=0, FSM forced to IDLE.
  - The sample counter keeps running.
  - On re-enable, the first computation happens at the next tick.
- Boundary rules:
  - A tick arriving while the FSM is not in IDLE cannot occur, since SAMPLE_PERIOD ≥ 5 is required. Assert this in simulation.
  - Reset mid-computation aborts the computation and returns all state to reset values in the next cycle.
  - setpoint changes take effect only at the next tick.
  - speed=0 with either direction bit gives meas=0.

Decomposition:
- Package wheel_ctrl_pkg holds:
  - Enum state_t {IDLE, ERR, INTEG, MUL, OUT}.
  - Localparams for the encoder word layout (ENC_DIR_BIT=16, ENC_SPEED_MSB=15).
  - A signed saturate function.
- Sub-module pwm_gen (counter, period-boundary duty load, |duty| compare, dir_out) is natural and separately testable. The PI FSM stays in the top.

Test Plan (bench overrides SAMPLE_PERIOD=100, PWM_PERIOD=1000, SHIFT=8):
- Reset: hold reset 3 cycles with random inputs -> pwm_out=0, dir_out=1, sat=0; no sample_tick before cycle 99 after release.
- P-only forward: enable=1, kp=16, ki=0, setpoint=100, enc_in={16'h1, 16'd50} -> duty_cmd=3 at tick+4; after the next PWM wrap, pwm_out is high exactly 3 of every 1000 clocks; dir_out=1.
- Reverse measurement: setpoint=-100, enc_in={16'h0, 16'd20}, kp=128, ki=0 -> err=-80, u=-40, dir_out=0, 40/1000 duty.
- Saturation and anti-windup: kp=255, ki=255, setpoint=30000, enc_in=0 -> duty_cmd=+1000, sat=1, pwm_out constant 1. Integrator grows only while unsaturated or once err turns negative. After setpoint=0, the integrator is not stuck at INT_LIM.
- Enable drop mid-loop: deassert enable in MUL -> next cycle pwm_out=0, integrator=0. Re-enable -> first update at the next tick+4.
- PWM glitch-free update: change duty_cmd mid PWM period -> pwm_out waveform for the current period unchanged; new duty from the next counter=0.
